mem_access_ctrl: RTL and testbench

//  Sequences the shared 64-entry sparse-matrix memory: one byte-stream writer packs entries, two read requesters share the port.

---
 rtl/mem_ctrl_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 24 ++
 rtl/mem_access_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the sparse-matrix memory access controller.
package mem_ctrl_pkg;

    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 64;
    localparam int BYTE_W        = 8;
    localparam int DEF_ENTRIES   = 64;
    localparam int DEF_MAX_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_t;

    // Round-robin tie break: the side that did not win last time.
    function automatic grant_t other_grant(input grant_t g);
        return (g == GNT_A) ? GNT_B : GNT_A;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// A lone request wins outright; a tie goes to the side that was not granted last.
module rr_arb2
    import mem_ctrl_pkg::*;
(
    input  logic   i_req_a,
    input  logic   i_req_b,
    input  grant_t i_last_grant,
    output logic   o_valid,
    output grant_t o_grant
);

    // Grant selection
    always_comb begin
        o_valid = i_req_a | i_req_b;
        if (i_req_a && i_req_b)
            o_grant = other_grant(i_last_grant);
        else if (i_req_a)
            o_grant = GNT_A;
        else
            o_grant = GNT_B;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer for the shared 64-entry sparse-matrix memory.
// One byte-stream writer packs entries; two read requesters (A = row-pointer
// fetcher, B = value/column fetcher) share the read port through rr_arb2.
// Optional performance counters are built when MEM_ACCESS_PERF_EN is defined.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ENTRIES   = DEF_ENTRIES,
    parameter int MAX_BYTES = DEF_MAX_BYTES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [BYTE_W-1:0] wr_byte,
    input  logic              wr_last,
    input  logic              rd_req_a,
    input  logic              rd_req_b,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              rd_valid_a,
    output logic              rd_valid_b,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic [ADDR_W-1:0] entry_count,
    output logic              mem_full,
    output logic              mem_reset,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_writePtr,
    output logic [ADDR_W-1:0] mem_readPtr,
    output logic [BYTE_W-1:0] mem_inData,
    input  logic [DATA_W-1:0] mem_outData
`ifdef MEM_ACCESS_PERF_EN
    ,
    output logic [31:0]       perf_wr_bytes,
    output logic [31:0]       perf_rd_a,
    output logic [31:0]       perf_rd_b,
    output logic [31:0]       perf_conflicts
`endif
);

    localparam int                BC_W  = $clog2(MAX_BYTES + 1);
    localparam logic [ADDR_W-1:0] L_ENT = ADDR_W'(ENTRIES);
    localparam logic [ADDR_W-1:0] L_TOP = ADDR_W'(ENTRIES - 1);
    localparam logic [BC_W-1:0]   L_MAXB = BC_W'(MAX_BYTES);

    state_t            r_state;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_count;
    logic [BC_W-1:0]   r_bcnt;
    grant_t            r_last_gnt;
    grant_t            r_gnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_pend;

    logic   w_any_req;
    logic   w_both_req;
    logic   w_full;
    logic   w_wr_acc;
    logic   w_go_write;
    logic   w_resp;
    logic   w_err;
    logic   w_arb_vld;
    grant_t w_gnt;

    rr_arb2 u_arb (
        .i_req_a      (rd_req_a),
        .i_req_b      (rd_req_b),
        .i_last_grant (r_last_gnt),
        .o_valid      (w_arb_vld),
        .o_grant      (w_gnt)
    );

    // Decode of the current cycle; clear masks every side effect of the aborted op
    always_comb begin
        w_any_req  = w_arb_vld;
        w_both_req = rd_req_a & rd_req_b;
        w_full     = (r_count == L_ENT);
        w_wr_acc   = (r_state == WRITE) && wr_valid && !clear;
        // A pending read turn only blocks writes while someone is still asking.
        w_go_write = wr_valid && !w_full && !(r_pend && w_any_req);
        w_resp     = (r_state == RESP) && !clear;
        w_err      = (r_addr >= r_count);
    end

    // Memory-side and requester-side outputs
    always_comb begin
        wr_ready     = (r_state == WRITE) && !clear;
        mem_wen      = w_wr_acc;
        mem_inData   = (r_state == WRITE) ? wr_byte : '0;
        mem_writePtr = r_wptr;
        mem_readPtr  = (r_state == READ) ? r_addr : '0;
        mem_reset    = !reset_n || clear;
        rd_valid_a   = w_resp && (r_gnt == GNT_A);
        rd_valid_b   = w_resp && (r_gnt == GNT_B);
        rd_err       = w_resp && w_err;
        rd_data      = (w_resp && !w_err) ? mem_outData : '0;
        entry_count  = r_count;
        mem_full     = w_full;
    end

    // Main sequencer: IDLE -> WRITE|READ, WRITE -> IDLE, READ -> RESP -> IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_wptr     <= '0;
            r_count    <= '0;
            r_bcnt     <= '0;
            r_last_gnt <= GNT_B;
            r_gnt      <= GNT_A;
            r_addr     <= '0;
            r_pend     <= 1'b0;
        end else if (clear) begin
            r_state <= IDLE;
            r_wptr  <= '0;
            r_count <= '0;
            r_bcnt  <= '0;
            r_pend  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_go_write) begin
                        r_state <= WRITE;
                    end else if (w_any_req) begin
                        r_state <= READ;
                        r_gnt   <= w_gnt;
                        r_addr  <= (w_gnt == GNT_A) ? rd_addr_a : rd_addr_b;
                        r_pend  <= 1'b0;
                    end
                end
                WRITE: begin
                    if (w_wr_acc) begin
                        // Bytes past MAX_BYTES shift the oldest out; only the count saturates.
                        if (r_bcnt != L_MAXB)
                            r_bcnt <= r_bcnt + 1'b1;
                        if (wr_last) begin
                            r_wptr  <= (r_wptr == L_TOP) ? '0 : r_wptr + 1'b1;
                            if (r_count != L_ENT)
                                r_count <= r_count + 1'b1;
                            r_bcnt  <= '0;
                            r_pend  <= w_any_req;
                            r_state <= IDLE;
                        end
                    end
                end
                READ: begin
                    r_state <= RESP;
                end
                RESP: begin
                    r_last_gnt <= r_gnt;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] r_perf_wr;
    logic [31:0] r_perf_a;
    logic [31:0] r_perf_b;
    logic [31:0] r_perf_cf;

    // Free-running event counters, wrapping on overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_wr <= '0;
            r_perf_a  <= '0;
            r_perf_b  <= '0;
            r_perf_cf <= '0;
        end else if (clear) begin
            r_perf_wr <= '0;
            r_perf_a  <= '0;
            r_perf_b  <= '0;
            r_perf_cf <= '0;
        end else begin
            if (w_wr_acc)
                r_perf_wr <= r_perf_wr + 1'b1;
            if (rd_valid_a)
                r_perf_a <= r_perf_a + 1'b1;
            if (rd_valid_b)
                r_perf_b <= r_perf_b + 1'b1;
            if ((r_state == IDLE) && w_both_req)
                r_perf_cf <= r_perf_cf + 1'b1;
        end
    end

    // Counter outputs
    always_comb begin
        perf_wr_bytes  = r_perf_wr;
        perf_rd_a      = r_perf_a;
        perf_rd_b      = r_perf_b;
        perf_conflicts = r_perf_cf;
    end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a behavioural memory and
// reference model (entry values, entry count, last-served requester).
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_byte = '0;
    logic        wr_last = 1'b0;
    logic        rd_req_a = 1'b0;
    logic        rd_req_b = 1'b0;
    logic [15:0] rd_addr_a = '0;
    logic [15:0] rd_addr_b = '0;
    logic        rd_valid_a, rd_valid_b, rd_err, mem_full, mem_reset, mem_wen;
    logic [63:0] rd_data;
    logic [15:0] entry_count, mem_writePtr, mem_readPtr;
    logic [7:0]  mem_inData;
    logic [63:0] mem_outData;
`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] perf_wr_bytes, perf_rd_a, perf_rd_b, perf_conflicts;
`endif

    mem_access_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_byte      (wr_byte),
        .wr_last      (wr_last),
        .rd_req_a     (rd_req_a),
        .rd_req_b     (rd_req_b),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .rd_valid_a   (rd_valid_a),
        .rd_valid_b   (rd_valid_b),
        .rd_data      (rd_data),
        .rd_err       (rd_err),
        .entry_count  (entry_count),
        .mem_full     (mem_full),
        .mem_reset    (mem_reset),
        .mem_wen      (mem_wen),
        .mem_writePtr (mem_writePtr),
        .mem_readPtr  (mem_readPtr),
        .mem_inData   (mem_inData),
        .mem_outData  (mem_outData)
`ifdef MEM_ACCESS_PERF_EN
       ,.perf_wr_bytes  (perf_wr_bytes),
        .perf_rd_a      (perf_rd_a),
        .perf_rd_b      (perf_rd_b),
        .perf_conflicts (perf_conflicts)
`endif
    );

    always #5 clk = ~clk;

    // Memory behaviour: byte shift-in per write, registered read data
    logic [63:0] mem [0:63];
    always @(posedge clk) begin
        if (mem_reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            mem_outData <= '0;
        end else begin
            if (mem_wen)
                mem[mem_writePtr[5:0]] <= {mem[mem_writePtr[5:0]][55:0], mem_inData};
            mem_outData <= mem[mem_readPtr[5:0]];
        end
    end

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model state
    logic [63:0] ref_vals[$];
    bit          ref_last_b = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // An entry keeps only its newest eight bytes, oldest in the top byte.
    function automatic logic [63:0] pack_val(input int n, input logic [79:0] b);
        logic [63:0] acc = '0;
        for (int i = 0; i < n; i++) acc = (acc << 8) | 64'(b[79-8*i -: 8]);
        return acc;
    endfunction

    function automatic void ref_read(input int addr, output logic [63:0] d, output logic e);
        if (addr < ref_vals.size()) begin d = ref_vals[addr]; e = 1'b0; end
        else begin d = '0; e = 1'b1; end
    endfunction

    task automatic write_entry(input int n, input logic [79:0] b);
        int i = 0;
        int cyc = 0;
        wr_valid = 1'b1;
        while (i < n && cyc < 40) begin
            wr_byte = b[79-8*i -: 8];
            wr_last = (i == n - 1);
            @(negedge clk);
            if (wr_ready) begin
                if (i == 0) chk("wr_ptr", 64'(mem_writePtr), 64'(ref_vals.size()));
                i++;
            end
            tick();
            cyc++;
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        if (i < n) chk("wr_timeout", 64'(i), 64'(n));
        else ref_vals.push_back(pack_val(n, b));
    endtask

    // Issue one or two simultaneous read requests and check order, latency, data.
    task automatic do_reads(input bit ua, input bit ub, input int aa, input int ab);
        logic [63:0] da, db;
        logic        ea, eb;
        int   k = 0;
        int   served = 0;
        int   nreq = int'(ua) + int'(ub);
        bit   exp_a;
        ref_read(aa, da, ea);
        ref_read(ab, db, eb);
        exp_a = (ua && ub) ? ref_last_b : ua;
        rd_req_a = ua; rd_addr_a = 16'(aa);
        rd_req_b = ub; rd_addr_b = 16'(ab);
        while (served < nreq && k < 20) begin
            @(negedge clk);
            if (rd_valid_a || rd_valid_b) begin
                chk("rd_grant", {rd_valid_a, rd_valid_b}, {exp_a, !exp_a});
                chk("rd_latency", 64'(k), (served == 0) ? 64'd2 : 64'd5);
                chk("rd_data", rd_data, exp_a ? da : db);
                chk("rd_err", 64'(rd_err), 64'(exp_a ? ea : eb));
                ref_last_b = !exp_a;
                served++;
                tick();
                if (exp_a) rd_req_a = 1'b0; else rd_req_b = 1'b0;
                exp_a = !exp_a;
            end else begin
                tick();
            end
            k++;
        end
        if (served < nreq) chk("rd_timeout", 64'(served), 64'(nreq));
        rd_req_a = 1'b0;
        rd_req_b = 1'b0;
    endtask

    task automatic clear_mem;
        clear = 1'b1;
        @(negedge clk);
        chk("clr_mem_reset", 64'(mem_reset), 64'd1);
        tick();
        clear = 1'b0;
        ref_vals.delete();
        @(negedge clk);
        chk("clr_state", {entry_count, mem_writePtr, 15'd0, mem_reset}, '0);
        tick();
    endtask

    typedef struct {
        int          n;
        logic [79:0] bytes;
        logic [63:0] exp_val;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [79:0] rb;
        int          sz;
        vecs[0] = '{3,  80'h112233_00000000000000, 64'h0000_0000_0011_2233};
        vecs[1] = '{1,  80'hAA_000000000000000000, 64'h0000_0000_0000_00AA};
        vecs[2] = '{10, 80'h0102030405060708090A, 64'h0304_0506_0708_090A};
        vecs[3] = '{8,  80'hF0F1F2F3F4F5F6F7_0000, 64'hF0F1_F2F3_F4F5_F6F7};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {wr_ready, rd_valid_a, rd_valid_b, rd_err, mem_full, mem_wen,
                         entry_count, mem_writePtr, mem_readPtr, mem_inData}, '0);
        chk("rst_data", rd_data, '0);
        chk("rst_mem_reset", 64'(mem_reset), 64'd1);
        tick();
        reset_n = 1'b1;
        tick();

        // Table-driven entries, read back alternately by A and B
        for (int i = 0; i < 4; i++) begin
            write_entry(vecs[i].n, vecs[i].bytes);
            chk("tbl_ref", ref_vals[i], vecs[i].exp_val);
            chk("tbl_count", 64'(entry_count), 64'(i + 1));
            do_reads(i % 2 == 0, i % 2 == 1, 0, i);
        end

        // Ties alternate grants
        begin
`ifdef MEM_ACCESS_PERF_EN
            logic [31:0] cf0 = perf_conflicts;
`endif
            do_reads(1, 1, 1, 2);
            do_reads(1, 1, 3, 0);
`ifdef MEM_ACCESS_PERF_EN
            chk("perf_conflicts", 64'(perf_conflicts - cf0), 64'd2);
`endif
        end

        // Out-of-range read with two entries
        clear_mem();
        write_entry(2, 80'h1234_0000000000000000);
        write_entry(1, 80'h56_000000000000000000);
        do_reads(1, 0, 5, 0);

        // Continuous writer while B requests: B is served before the next write
        wr_valid = 1'b1; wr_byte = 8'h55; wr_last = 1'b0;
        @(negedge clk); chk("bw_idle_rdy", 64'(wr_ready), 64'd0);
        tick();
        @(negedge clk); chk("bw_wr1_rdy", 64'(wr_ready), 64'd1);
        tick();
        wr_byte = 8'h66; wr_last = 1'b1; rd_req_b = 1'b1; rd_addr_b = 16'd0;
        @(negedge clk); chk("bw_wr2_rdy", 64'(wr_ready), 64'd1);
        tick();
        ref_vals.push_back(64'h5566);
        wr_byte = 8'h77;
        @(negedge clk); chk("bw_blk1", {wr_ready, rd_valid_b}, 2'b00);
        tick();
        @(negedge clk); chk("bw_blk2", {wr_ready, rd_valid_b}, 2'b00);
        tick();
        @(negedge clk);
        chk("bw_rdv", {wr_ready, rd_valid_b}, 2'b01);
        chk("bw_data", rd_data, 64'h1234);
        tick();
        rd_req_b = 1'b0; ref_last_b = 1'b1;
        @(negedge clk); chk("bw_idle2", 64'(wr_ready), 64'd0);
        tick();
        @(negedge clk); chk("bw_wr3_rdy", 64'(wr_ready), 64'd1);
        tick();
        wr_valid = 1'b0; wr_last = 1'b0;
        ref_vals.push_back(64'h77);
        chk("bw_count", 64'(entry_count), 64'd4);
        do_reads(1, 0, 3, 0);
        do_reads(0, 1, 0, 2);

        // Randomized traffic against the reference model
        for (int it = 0; it < 80; it++) begin
            sz = ref_vals.size();
            if (sz >= 58) clear_mem();
            case ($urandom_range(0, 2))
                0: begin
                    rb = {$urandom(), $urandom(), 16'($urandom())};
                    write_entry($urandom_range(1, 10), rb);
                end
                1: do_reads($urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, sz + 3), 0);
                default: do_reads(1, 1, $urandom_range(0, sz + 3), $urandom_range(0, sz + 3));
            endcase
            if (!$urandom_range(0, 2)) begin
                // keep B-only reads covered too
                do_reads(0, 1, 0, $urandom_range(0, ref_vals.size() + 2));
            end
        end
        chk("rnd_count", 64'(entry_count), 64'(ref_vals.size()));

        // Fill to capacity
        clear_mem();
        for (int i = 0; i < 64; i++) begin
            rb = {8'(i), 72'h0};
            write_entry(1, rb);
        end
        @(negedge clk);
        chk("full_state", {mem_full, entry_count}, {1'b1, 16'd64});
        tick();
        wr_valid = 1'b1; wr_byte = 8'hEE; wr_last = 1'b1;
        begin
            logic seen = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                seen = seen | wr_ready | mem_wen;
                tick();
            end
            chk("full_no_ready", 64'(seen), 64'd0);
        end
        do_reads(1, 0, 63, 0);
        chk("full_ref63", ref_vals[63], 64'h3F);
        wr_valid = 1'b0; wr_last = 1'b0;
        clear_mem();

        // Reset in the middle of a read
        write_entry(2, 80'hABCD_0000000000000000);
        rd_req_a = 1'b1; rd_addr_a = 16'd0;
        tick();
        reset_n = 1'b0;
        #1;
        chk("rstmid_outs", {wr_ready, rd_valid_a, rd_valid_b, rd_err, mem_full, mem_wen,
                            entry_count, mem_writePtr, mem_readPtr, mem_inData}, '0);
        chk("rstmid_mem_reset", 64'(mem_reset), 64'd1);
        @(negedge clk);
        chk("rstmid_no_valid", {rd_valid_a, rd_data}, '0);
        tick();
        reset_n = 1'b1; rd_req_a = 1'b0;
        ref_vals.delete(); ref_last_b = 1'b1;
        tick();
        write_entry(1, 80'h09_000000000000000000);
        do_reads(1, 0, 0, 0);
        do_reads(1, 1, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
